uart_tx_arbiter: RTL and testbench

Shares the single uart_tx byte transmitter between NUM_REQ independent byte-stream requesters. Each requester is granted in round-robin order. A grant is held for a whole message, up to and including the byte flagged last, so messages from different requesters never interleave on TX. The block owns the uart_tx write_enable/data inputs and tracks the uart_tx TC (transmission complete) flag to pace bytes. It sits between the message sources (ROM sequencers, status reporters) and uart_tx.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the uart_tx arbiter: byte width and FSM state encoding.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_LOW  = 2'b10,
    WAIT_HIGH = 2'b11
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first asserted request found
// when searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Scan from the farthest candidate to the nearest so the nearest set request wins.
  always_comb begin
    found    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand     = (int'(rr_ptr) + k) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (req_valid[cand_idx]) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte-stream
// requesters. A grant is held for a whole message (through the byte flagged
// last) and bytes are paced by the uart_tx TC flag.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TC_WAIT_MAX = 8
) (
  input  logic                      clk,
  input  logic                      reset_bar,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_write_enable,
  input  logic                      tx_tc,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      err_no_start
);

  localparam int CNT_W = $clog2(TC_WAIT_MAX + 1);

  arb_state_t        state, state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic              last_flag;
  logic [BYTE_W-1:0] tx_data_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_inc;
  logic              timeout;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              owner_valid;
  logic              owner_last;
  logic [BYTE_W-1:0] owner_data;
  logic              fire;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .found     (pick_found),
    .index     (pick_idx)
  );

  // Select the current owner's byte lane.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) owner_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign owner_valid = req_valid[grant_id];
  assign owner_last  = req_last[grant_id];

  // A byte is handed to uart_tx only when the transmitter is idle and the owner offers one.
  assign fire = (state == ISSUE) && tx_tc && owner_valid;

  // The byte is presented on the write cycle itself and held in tx_data_q afterwards.
  assign tx_write_enable = fire;
  assign req_ready       = fire ? (NUM_REQ'(1) << grant_id) : '0;
  assign tx_data         = fire ? owner_data : tx_data_q;

  // The write cycle counts as the first TC-high cycle, so the error fires
  // TC_WAIT_MAX cycles after the write pulse.
  assign wait_cnt_inc = wait_cnt + CNT_W'(1);
  assign timeout      = tx_tc && (wait_cnt_inc >= CNT_W'(TC_WAIT_MAX));

  // State register.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pick_found)          state_next = ISSUE;
      ISSUE:     if (fire)                state_next = WAIT_LOW;
      WAIT_LOW:  if (!tx_tc || timeout)   state_next = WAIT_HIGH;
      WAIT_HIGH: if (tx_tc)               state_next = last_flag ? IDLE : ISSUE;
      default:                            state_next = IDLE;
    endcase
  end

  // Grant, pointer, held byte, TC-wait counter and sticky error.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      grant_id     <= '0;
      busy         <= 1'b0;
      last_flag    <= 1'b0;
      tx_data_q    <= '0;
      wait_cnt     <= '0;
      err_no_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (fire) begin
            tx_data_q <= owner_data;
            last_flag <= owner_last;
            wait_cnt  <= CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (tx_tc) begin
            wait_cnt <= wait_cnt_inc;
            if (timeout) err_no_start <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (tx_tc && last_flag) begin
            rr_ptr <= grant_id;
            busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a uart_tx TC model, per-requester
// message queues and a message-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int TC_WAIT_MAX = 8;
  localparam int FRAME       = 10;

  logic                 clk = 1'b0;
  logic                 reset_bar = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*8-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_write_enable;
  logic                 tx_tc;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 err_no_start;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TC_WAIT_MAX(TC_WAIT_MAX)) dut (
    .clk(clk), .reset_bar(reset_bar), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_write_enable(tx_write_enable), .tx_tc(tx_tc), .grant_id(grant_id),
    .busy(busy), .err_no_start(err_no_start)
  );

  initial forever #5 clk = ~clk;

  // uart_tx model: TC low for FRAME cycles after each write, or stuck high.
  logic stuck = 1'b0;
  int   frame_cnt;
  always @(posedge clk or negedge reset_bar) begin
    if (!reset_bar)                        frame_cnt <= 0;
    else if (tx_write_enable && !stuck)    frame_cnt <= FRAME;
    else if (frame_cnt != 0)               frame_cnt <= frame_cnt - 1;
  end
  assign tx_tc = stuck ? 1'b1 : (frame_cnt == 0);

  int checks = 0;
  int errors = 0;

  // Requester message storage: {last, byte}
  logic [8:0] mem [NUM_REQ][64];
  int         head [NUM_REQ];
  int         tail [NUM_REQ];
  logic       hold [NUM_REQ];
  logic       rnd_mode = 1'b0;

  // Observations taken at the falling edge
  logic [NUM_REQ-1:0] obs_ready, obs_valid;
  logic [7:0]         obs_data;
  logic               obs_we, obs_busy, obs_err, obs_tc;
  logic [ID_W-1:0]    obs_grant;
  int                 cyc = 0;

  // Write log and expected log
  int         wn;
  int         wlog_src [256];
  logic [7:0] wlog_data [256];
  int         exp_n;
  int         exp_src [256];
  logic [7:0] exp_data [256];

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (last + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic pending();
    for (int i = 0; i < NUM_REQ; i++) if (head[i] < tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_msg(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      mem[r][tail[r]] = {(k == n - 1), 8'(base + k)};
      tail[r]++;
    end
  endtask

  // Message-level round robin over queued messages, all requesters continuously valid.
  task automatic build_expected();
    int h [NUM_REQ];
    int last, r;
    logic done;
    for (int i = 0; i < NUM_REQ; i++) h[i] = head[i];
    last = NUM_REQ - 1;
    exp_n = 0;
    forever begin
      r = -1;
      for (int k = 1; k <= NUM_REQ && r < 0; k++)
        if (h[(last + k) % NUM_REQ] < tail[(last + k) % NUM_REQ]) r = (last + k) % NUM_REQ;
      if (r < 0) break;
      done = 1'b0;
      while (!done) begin
        exp_src[exp_n] = r;
        exp_data[exp_n] = mem[r][h[r]][7:0];
        done = mem[r][h[r]][8];
        exp_n++;
        h[r]++;
      end
      last = r;
    end
  endtask

  // One clock: consume accepted byte, drive requesters, sample outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (obs_ready[i] && head[i] < tail[i]) head[i]++;
      if (head[i] < tail[i]) begin
        req_valid[i] = !hold[i] && (!rnd_mode || ($urandom_range(0, 3) != 0));
        req_data[i*8 +: 8] = mem[i][head[i]][7:0];
        req_last[i] = mem[i][head[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    cyc++;
    obs_ready = req_ready; obs_valid = req_valid; obs_data = tx_data;
    obs_we = tx_write_enable; obs_busy = busy; obs_err = err_no_start;
    obs_tc = tx_tc; obs_grant = grant_id;
    if (obs_we && wn < 256) begin
      wlog_src[wn] = onehot_idx(obs_ready);
      wlog_data[wn] = obs_data;
      wn++;
    end
  endtask

  task automatic do_reset();
    reset_bar = 1'b0; rnd_mode = 1'b0; stuck = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin head[i] = 0; tail[i] = 0; hold[i] = 1'b0; end
    obs_ready = '0; obs_busy = 1'b0; wn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_bar = 1'b1;
  endtask

  task automatic test_reset();
    reset_bar = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (tx_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", tx_write_enable); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_txdata got %h exp 00", tx_data); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    checks++; if (err_no_start !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_no_start); end
    do_reset();
    repeat (5) step();
    checks++; if (obs_busy !== 1'b0 || wn != 0) begin errors++; $display("FAIL idle_quiet busy %b writes %0d exp 0 0", obs_busy, wn); end
  endtask

  task automatic test_single_stream();
    int tc_rise, fall;
    logic seen_busy, prev_tc;
    do_reset();
    add_msg(0, 3, 8'h41);
    build_expected();
    tc_rise = -1; fall = -1; seen_busy = 1'b0; prev_tc = 1'b1;
    for (int c = 0; c < 300 && fall < 0; c++) begin
      step();
      if (obs_busy) begin
        seen_busy = 1'b1;
        checks++; if (obs_grant !== 2'd0) begin errors++; $display("FAIL single_grant got %0d exp 0", obs_grant); end
      end
      if (wn == 3 && obs_tc && !prev_tc && tc_rise < 0) tc_rise = cyc;
      if (seen_busy && !obs_busy) fall = cyc;
      prev_tc = obs_tc;
    end
    checks++; if (wn != exp_n) begin errors++; $display("FAIL single_count got %0d exp %0d", wn, exp_n); end
    for (int k = 0; k < exp_n && k < wn; k++) begin
      checks++; if (wlog_data[k] !== exp_data[k]) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", k, wlog_data[k], exp_data[k]); end
    end
    checks++; if (fall < 0 || tc_rise < 0 || fall != tc_rise + 1) begin errors++; $display("FAIL single_busy_fall got cycle %0d exp %0d", fall, tc_rise + 1); end
  endtask

  task automatic test_rr_pair();
    do_reset();
    add_msg(1, 2, 8'h10);
    add_msg(3, 2, 8'h30);
    add_msg(1, 2, 8'h12);
    build_expected();
    for (int c = 0; c < 500; c++) begin
      step();
      if (!pending() && !obs_busy) break;
    end
    checks++; if (wn != exp_n) begin errors++; $display("FAIL rr_count got %0d exp %0d", wn, exp_n); end
    for (int k = 0; k < exp_n && k < wn; k++) begin
      checks++; if (wlog_src[k] != exp_src[k] || wlog_data[k] !== exp_data[k]) begin
        errors++; $display("FAIL rr_seq[%0d] got %0d:%h exp %0d:%h", k, wlog_src[k], wlog_data[k], exp_src[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_owner_stall();
    do_reset();
    add_msg(2, 3, 8'h20);
    for (int c = 0; c < 100 && wn < 1; c++) step();
    checks++; if (wn != 1) begin errors++; $display("FAIL stall_first_write got %0d exp 1", wn); end
    hold[2] = 1'b1;
    add_msg(0, 1, 8'h07);
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL stall_we got %b exp 0", obs_we); end
      checks++; if (obs_grant !== 2'd2 || obs_busy !== 1'b1) begin errors++; $display("FAIL stall_grant got %0d/%b exp 2/1", obs_grant, obs_busy); end
      checks++; if (obs_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_ready0 got %b exp 0", obs_ready[0]); end
    end
    hold[2] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (!pending() && !obs_busy) break;
    end
    exp_n = 4;
    exp_src[0] = 2; exp_src[1] = 2; exp_src[2] = 2; exp_src[3] = 0;
    exp_data[0] = 8'h20; exp_data[1] = 8'h21; exp_data[2] = 8'h22; exp_data[3] = 8'h07;
    checks++; if (wn != exp_n) begin errors++; $display("FAIL stall_count got %0d exp %0d", wn, exp_n); end
    for (int k = 0; k < exp_n && k < wn; k++) begin
      checks++; if (wlog_src[k] != exp_src[k] || wlog_data[k] !== exp_data[k]) begin
        errors++; $display("FAIL stall_seq[%0d] got %0d:%h exp %0d:%h", k, wlog_src[k], wlog_data[k], exp_src[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_tc_stuck();
    do_reset();
    stuck = 1'b1;
    add_msg(1, 2, 8'h5A);
    for (int c = 0; c < 50 && wn < 1; c++) step();
    checks++; if (wn != 1) begin errors++; $display("FAIL stuck_first_write got %0d exp 1", wn); end
    for (int k = 1; k <= TC_WAIT_MAX; k++) begin
      step();
      checks++; if (obs_err !== (k == TC_WAIT_MAX)) begin
        errors++; $display("FAIL stuck_err_cycle%0d got %b exp %b", k, obs_err, (k == TC_WAIT_MAX));
      end
    end
    for (int c = 0; c < 100; c++) begin
      step();
      if (!pending() && !obs_busy) break;
    end
    checks++; if (wn != 2 || wlog_data[1] !== 8'h5B) begin errors++; $display("FAIL stuck_next_byte got %0d writes data %h exp 2 5b", wn, wlog_data[1]); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL stuck_err_sticky got %b exp 1", obs_err); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL stuck_done got busy %b exp 0", obs_busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_msg(0, 4, 8'hA0);
    for (int c = 0; c < 100 && wn < 2; c++) step();
    checks++; if (wn != 2) begin errors++; $display("FAIL rmid_second_write got %0d exp 2", wn); end
    @(posedge clk);
    #2;
    reset_bar = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (tx_write_enable !== 1'b0 || req_ready !== '0) begin errors++; $display("FAIL rmid_we_ready got %b/%b exp 0/0", tx_write_enable, req_ready); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_txdata got %h exp 00", tx_data); end
    checks++; if (grant_id !== '0 || err_no_start !== 1'b0) begin errors++; $display("FAIL rmid_grant_err got %0d/%b exp 0/0", grant_id, err_no_start); end
    do_reset();
    add_msg(2, 1, 8'hC2);
    add_msg(0, 2, 8'hC0);
    build_expected();
    for (int c = 0; c < 300; c++) begin
      step();
      if (!pending() && !obs_busy) break;
    end
    checks++; if (wn != exp_n) begin errors++; $display("FAIL rmid_count got %0d exp %0d", wn, exp_n); end
    for (int k = 0; k < exp_n && k < wn; k++) begin
      checks++; if (wlog_src[k] != exp_src[k] || wlog_data[k] !== exp_data[k]) begin
        errors++; $display("FAIL rmid_seq[%0d] got %0d:%h exp %0d:%h", k, wlog_src[k], wlog_data[k], exp_src[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_all_four();
    int last_we;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) add_msg(i, 1, 8'(8'h80 + i));
    add_msg(0, 1, 8'h90);
    build_expected();
    last_we = -100;
    for (int c = 0; c < 500; c++) begin
      step();
      checks++; if ($countones(obs_ready) > 1 || ((obs_ready != '0) !== obs_we)) begin
        errors++; $display("FAIL four_ready_we got ready %b we %b exp one-hot matching", obs_ready, obs_we);
      end
      if (obs_ready != '0) begin
        checks++; if (obs_ready[obs_grant] !== 1'b1) begin errors++; $display("FAIL four_ready_owner got ready %b grant %0d", obs_ready, obs_grant); end
      end
      if (obs_we) begin
        checks++; if (cyc - last_we < 3) begin errors++; $display("FAIL four_spacing got %0d exp >=3", cyc - last_we); end
        last_we = cyc;
      end
      if (!pending() && !obs_busy) break;
    end
    checks++; if (wn != exp_n) begin errors++; $display("FAIL four_count got %0d exp %0d", wn, exp_n); end
    for (int k = 0; k < exp_n && k < wn; k++) begin
      checks++; if (wlog_src[k] != exp_src[k] || wlog_data[k] !== exp_data[k]) begin
        errors++; $display("FAIL four_seq[%0d] got %0d:%h exp %0d:%h", k, wlog_src[k], wlog_data[k], exp_src[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_random();
    int model_last, owner, open, src, total;
    logic prev_busy;
    logic [NUM_REQ-1:0] prev_valid;
    logic done;
    do_reset();
    rnd_mode = 1'b1;
    total = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int nm;
      nm = $urandom_range(1, 3);
      for (int m = 0; m < nm; m++) begin
        int nb;
        nb = $urandom_range(1, 4);
        add_msg(i, nb, 8'($urandom));
        total += nb;
      end
    end
    model_last = NUM_REQ - 1; owner = -1; open = -1;
    prev_busy = 1'b0; prev_valid = '0; done = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      step();
      if (!prev_busy && obs_busy) begin
        owner = rr_pick(prev_valid, model_last);
        checks++; if (int'(obs_grant) != owner) begin errors++; $display("FAIL rand_arb got %0d exp %0d", obs_grant, owner); end
      end
      if (prev_busy && !obs_busy) model_last = owner;
      if (obs_we) begin
        src = onehot_idx(obs_ready);
        checks++; if (src != owner || src < 0 || obs_data !== mem[src < 0 ? 0 : src][head[src < 0 ? 0 : src]][7:0]) begin
          errors++; $display("FAIL rand_byte got src %0d data %h exp src %0d", src, obs_data, owner);
        end
        checks++; if (open >= 0 && src != open) begin errors++; $display("FAIL rand_interleave got src %0d exp %0d", src, open); end
        if (src >= 0) open = mem[src][head[src]][8] ? -1 : src;
      end
      prev_busy = obs_busy; prev_valid = obs_valid;
      if (!pending() && !obs_busy) begin done = 1'b1; break; end
    end
    checks++; if (!done || wn != total) begin errors++; $display("FAIL rand_complete got done %b writes %0d exp 1 %0d", done, wn, total); end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_rr_pair();
    test_owner_stall();
    test_tc_stuck();
    test_reset_mid();
    test_all_four();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
